// File: rtl/pe_array_my.sv
// pe_array_my: matrix-vector multiply engine, C = A*B, with VECTOR_SIZE PEs.
//   On start it streams B then A (row-major) out of an external word BRAM
//   into a shared B buffer and per-PE row buffers. It then runs VECTOR_SIZE
//   parallel MAC cycles and writes C back to the BRAM.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN : clock, async active-low reset
//   start / done               : one-cycle request / one-cycle completion pulse
//   BRAM_ADDR/WRDATA/WE        : byte address, write data, byte enables (registered)
//   BRAM_CLK                   : inverted system clock for the BRAM
//   BRAM_RDDATA                : read data, two capture edges after the address

// Per-lane PE: local row buffer plus a 32-bit wrapping accumulator.
module pe_array_my_pe #(
  parameter int L_RAM_SIZE = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_wr_en,
  input  logic [L_RAM_SIZE-1:0] i_wr_idx,
  input  logic [31:0]           i_wr_data,
  input  logic                  i_mac_en,
  input  logic [L_RAM_SIZE-1:0] i_k,
  input  logic [31:0]           i_b,
  output logic [31:0]           o_acc
);
  localparam int DEPTH = 2**L_RAM_SIZE;

  logic [DEPTH-1:0][31:0] r_buf;
  logic [31:0]            r_acc;
  logic [31:0]            w_prod;

  // Only the low 32 bits of the product are kept.
  assign w_prod = r_buf[i_k] * i_b;
  assign o_acc  = r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf <= '0;
      r_acc <= '0;
    end else begin
      if (i_wr_en) r_buf[i_wr_idx] <= i_wr_data;
      if (i_clr)         r_acc <= '0;
      else if (i_mac_en) r_acc <= r_acc + w_prod;
    end
  end
endmodule

module pe_array_my #(
  parameter int L_RAM_SIZE  = 6,
  parameter int VECTOR_SIZE = 16
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        start,
  output logic        done,
  output logic [31:0] BRAM_ADDR,
  output logic [31:0] BRAM_WRDATA,
  output logic [3:0]  BRAM_WE,
  output logic        BRAM_CLK,
  input  logic [31:0] BRAM_RDDATA
);
  localparam int N     = VECTOR_SIZE;
  localparam int KW    = (N > 1) ? $clog2(N) : 1;
  localparam int TOTAL = N + N*N;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam logic [KW-1:0] LAST   = KW'(N - 1);
  localparam logic [31:0]   C_BASE = 32'(N + N*N);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_WRITE, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [CW-1:0]         r_cnt;       // next word index to issue during LOAD
  logic [1:0]            r_vld_pipe;  // read-in-flight tracker, [1] = data valid now
  logic                  r_in_a;      // capture side has moved past B into A
  logic [KW-1:0]         r_ccol, r_crow;
  logic [KW-1:0]         r_k, r_i;
  logic [N-1:0][31:0]    r_b;
  logic [31:0]           r_addr, r_wrdata;
  logic [3:0]            r_we;
  logic                  r_done;
  logic [N-1:0][31:0]    w_acc;
  logic                  w_start, w_issue, w_cap, w_cap_last;

  assign BRAM_CLK    = ~S_AXI_ACLK;
  assign BRAM_ADDR   = r_addr;
  assign BRAM_WRDATA = r_wrdata;
  assign BRAM_WE     = r_we;
  assign done        = r_done;

  assign w_start    = (r_state == S_IDLE) && start;
  assign w_issue    = (r_state == S_LOAD) && (r_cnt != CW'(TOTAL));
  assign w_cap      = (r_state == S_LOAD) && r_vld_pipe[1];
  // Reads return in issue order, so the capture position is tracked by
  // its own row/col counters rather than by tagging each request.
  assign w_cap_last = w_cap && r_in_a && (r_crow == LAST) && (r_ccol == LAST);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_state <= S_IDLE;
    else                r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)      w_next = S_LOAD;
      S_LOAD:  if (w_cap_last) w_next = S_CALC;
      S_CALC:  if (r_k == LAST) w_next = S_WRITE;
      S_WRITE: if (r_i == LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_cnt      <= '0;
      r_vld_pipe <= '0;
      r_in_a     <= 1'b0;
      r_ccol     <= '0;
      r_crow     <= '0;
      r_k        <= '0;
      r_i        <= '0;
      r_b        <= '0;
      r_addr     <= '0;
      r_wrdata   <= '0;
      r_we       <= '0;
      r_done     <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[0], w_issue};
      r_done     <= (r_state == S_DONE);
      r_we       <= '0;
      case (r_state)
        S_IDLE: if (start) begin
          r_cnt  <= '0;
          r_in_a <= 1'b0;
          r_ccol <= '0;
          r_crow <= '0;
          r_k    <= '0;
          r_i    <= '0;
        end
        S_LOAD: begin
          if (w_issue) begin
            r_addr <= 32'(r_cnt) << 2;
            r_cnt  <= r_cnt + CW'(1);
          end
          if (w_cap) begin
            if (!r_in_a) r_b[r_ccol] <= BRAM_RDDATA;
            if (r_ccol == LAST) begin
              r_ccol <= '0;
              if (!r_in_a) r_in_a <= 1'b1;
              else         r_crow <= r_crow + KW'(1);
            end else begin
              r_ccol <= r_ccol + KW'(1);
            end
          end
        end
        S_CALC:  r_k <= (r_k == LAST) ? '0 : r_k + KW'(1);
        S_WRITE: begin
          r_addr   <= (C_BASE + 32'(r_i)) << 2;
          r_wrdata <= w_acc[r_i];
          r_we     <= 4'hF;
          r_i      <= (r_i == LAST) ? '0 : r_i + KW'(1);
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_pe
    pe_array_my_pe #(.L_RAM_SIZE(L_RAM_SIZE)) u_pe (
      .clk       (S_AXI_ACLK),
      .rst_n     (S_AXI_ARESETN),
      .i_clr     (w_start),
      .i_wr_en   (w_cap && r_in_a && (r_crow == KW'(g))),
      .i_wr_idx  (L_RAM_SIZE'(r_ccol)),
      .i_wr_data (BRAM_RDDATA),
      .i_mac_en  (r_state == S_CALC),
      .i_k       (L_RAM_SIZE'(r_k)),
      .i_b       (r_b[r_k]),
      .o_acc     (w_acc[g])
    );
  end
endmodule

// File: tb/tb_pe_array_my.sv
// Bench for pe_array_my: BRAM model on the falling edge, scoreboard of
// expected C writes filled at start, monitor popping on every BRAM write.
module tb_pe_array_my;
  localparam int N   = 16;
  localparam int TOT = N + N*N;
  localparam int CB  = N + N*N;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, ld = 1'b0;
  logic        done, bclk;
  logic [31:0] addr, wrdata, rddata, q1;
  logic [3:0]  we;
  logic [31:0] mem [0:511];
  logic [31:0] img [0:511];

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t sbq[$];
  int n_cmp = 0, n_err = 0, n_wr = 0, n_done = 0;

  always #5 clk = ~clk;

  pe_array_my #(.L_RAM_SIZE(6), .VECTOR_SIZE(N)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start), .done(done),
    .BRAM_ADDR(addr), .BRAM_WRDATA(wrdata), .BRAM_WE(we), .BRAM_CLK(bclk),
    .BRAM_RDDATA(rddata));

  // BRAM: samples on the inverted clock; two-stage output so data for an
  // address launched at rising edge t is presented for the edge ending t+1.
  always @(negedge clk) begin
    if (ld) begin
      for (int i = 0; i < 512; i++) mem[i] <= img[i];
    end else if (we != 4'h0) begin
      mem[addr[10:2]] <= wrdata;
    end
    q1     <= mem[addr[10:2]];
    rddata <= q1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Monitor: every BRAM write must match the head of the scoreboard.
  initial forever begin
    wr_t e;
    @(negedge clk);
    if (rst_n) begin
      if (we != 4'h0) begin
        n_wr++;
        if (sbq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL stray_write: got addr %h we %h, required no write", addr, we);
        end else begin
          e = sbq.pop_front();
          chk("wr_addr", addr, e.addr);
          chk("wr_data", wrdata, e.data);
          chk("wr_we", {28'b0, we}, 32'hF);
        end
      end
      if (done) n_done++;
    end
  end

  // Reference: C[i] = sum_j A[i][j]*B[j], 32-bit wrapping arithmetic.
  task automatic push_expected(output logic [31:0] c [N]);
    for (int i = 0; i < N; i++) begin
      wr_t e;
      c[i] = 32'h0;
      for (int j = 0; j < N; j++) c[i] = c[i] + img[N + i*N + j] * img[j];
      e.addr = 32'((CB + i) * 4);
      e.data = c[i];
      sbq.push_back(e);
    end
  endtask

  task automatic load_mem();
    for (int i = TOT; i < 512; i++) img[i] = 32'hDEADBEEF;
    @(posedge clk); #1 ld = 1'b1;
    @(posedge clk); #1 ld = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_case(input string nm);
    logic [31:0] c [N];
    int lat, bad;
    bit got;
    load_mem();
    push_expected(c);
    n_wr = 0; n_done = 0; lat = 0; got = 1'b0;
    pulse_start();
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (done) got = 1'b1;
    end
    chk({nm, "_done_seen"}, 32'(got), 32'd1);
    chk({nm, "_latency_le_320"}, 32'(lat <= 320), 32'd1);
    repeat (4) @(negedge clk);
    chk({nm, "_done_pulses"}, 32'(n_done), 32'd1);
    chk({nm, "_we_cycles"}, 32'(n_wr), 32'(N));
    chk({nm, "_sb_left"}, 32'(sbq.size()), 32'd0);
    bad = 0;
    for (int i = 0; i < TOT; i++) if (mem[i] !== img[i]) bad++;
    chk({nm, "_ab_intact"}, 32'(bad), 32'd0);
    for (int i = 0; i < N; i++) chk({nm, "_memC"}, mem[CB + i], c[i]);
    sbq.delete();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) img[i] = 32'h0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_wrdata", wrdata, 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // identity, B[j]=j+1 -> C[i]=i+1
    for (int j = 0; j < N; j++) img[j] = 32'(j + 1);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) img[N + i*N + j] = (i == j) ? 32'd1 : 32'd0;
    run_case("identity");

    // all ones, B=2 -> 32
    for (int j = 0; j < N; j++) img[j] = 32'd2;
    for (int i = 0; i < N*N; i++) img[N + i] = 32'd1;
    run_case("ones");

    // A=i-j, B=-1 -> 120-16i
    for (int j = 0; j < N; j++) img[j] = 32'hFFFFFFFF;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) img[N + i*N + j] = 32'(i - j);
    run_case("i_minus_j");

    // overflow wrap: 16 * 0xFFFFFFFE -> 0xFFFFFFE0
    for (int j = 0; j < N; j++) img[j] = 32'd2;
    for (int i = 0; i < N*N; i++) img[N + i] = 32'h7FFFFFFF;
    run_case("wrap");

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < TOT; i++)
        img[i] = (r == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
      run_case("random");
    end

    // abort in CALC, then a clean rerun with start held into the run
    for (int i = 0; i < TOT; i++) img[i] = $urandom;
    load_mem();
    pulse_start();
    repeat (280) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_we", 32'(we), 32'd0);
    chk("abort_addr", addr, 32'd0);
    chk("abort_wrdata", wrdata, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    run_case("after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pe_array_my.md
Name: pe_array_my

Overview:
- Matrix-vector multiply engine built from VECTOR_SIZE parallel processing elements (PEs).
- On a start pulse it reads vector B and matrix A from an external single-port word BRAM, computes C = A·B, and writes C back to the same BRAM.
- It then pulses done. It sits between a host that preloads the BRAM and a BRAM that is clocked on the inverted system clock.

Parameters:
- L_RAM_SIZE, 6: log2 depth of each PE's local row buffer. 2^L_RAM_SIZE must be ≥ VECTOR_SIZE.
- VECTOR_SIZE, 16: N, the vector length, matrix dimension and PE count.

Ports:
- S_AXI_ACLK  in  1  system clock, rising-edge.
- S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle request to begin an operation.
- done  out  1  one-cycle pulse when C has been written.
- BRAM_ADDR  out  32  byte address (word index × 4).
- BRAM_WRDATA  out  32  write data.
- BRAM_WE  out  4  byte write enables.
- BRAM_CLK  out  1  equals ~S_AXI_ACLK.
- BRAM_RDDATA  in  32  read data.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low on S_AXI_ARESETN.
- Reset values:
  - done=0, BRAM_ADDR=0, BRAM_WRDATA=0, BRAM_WE=0.
  - FSM in IDLE; all accumulators, buffers and counters cleared.
- Memory map (word index, N=VECTOR_SIZE), all operands 32-bit two's-complement:
  - B[j] at j, for 0..N-1.
  - A[i][j] at N + i*N + j, row-major.
  - C[i] at N + N² + i.
  - For N=16: B at bytes 0x000–0x03C, A at 0x040–0x43C, C at 0x440–0x47C.
- BRAM timing:
  - The BRAM samples address, data and WE on BRAM_CLK rising, i.e. S_AXI_ACLK falling.
  - An address driven from a rising edge at cycle t returns BRAM_RDDATA that the block captures at the rising edge ending cycle t+1.
  - Reads are pipelined one per cycle.
- FSM states: IDLE, LOAD, CALC, WRITE, DONE.
- IDLE:
  - BRAM_WE=0.
  - start=1 sampled on a rising edge moves to LOAD.
- LOAD:
  - Issues reads for word indices 0 .. N+N²-1, one per cycle, ascending.
  - Data for indices < N goes to the shared B buffer, element j.
  - Data at N+i*N+j goes to PE i's local buffer, entry j.
  - After the last captured word, moves to CALC.
- CALC:
  - Runs N cycles, k = 0..N-1.
  - Every PE i does acc_i ← acc_i + local_i[k] * B[k] in parallel.
  - The product keeps its low 32 bits; the accumulator is 32 bits and wraps on overflow, with no saturation.
  - acc_i is cleared on entry to LOAD.
- WRITE:
  - Runs N cycles, i = 0..N-1.
  - BRAM_ADDR = (N+N²+i)*4, BRAM_WRDATA = acc_i, BRAM_WE = 4'hF.
  - After the last write, BRAM_WE returns to 0 and the FSM moves to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - BRAM contents remain valid for the host.
- Latency: for N=16, done rises no later than 320 cycles after start is sampled.
- start while not in IDLE is ignored. start held high across the DONE→IDLE transition begins a new run.
- Reset mid-operation aborts immediately:
  - All outputs return to reset values and the FSM goes to IDLE.
  - A partially written C region is left as-is.
- Any write to A or B addresses is prohibited; only the C region is ever written.

Test Plan:
- Reset held 5 cycles, released, start pulsed 1 cycle after 5 more -> BRAM_WE stays 0 through LOAD/CALC; done pulses once; WE=4'hF on exactly 16 cycles at bytes 0x440..0x47C.
- A = identity, B[j]=j+1 -> C[i]=i+1 at word 272+i; A/B region unchanged.
- A[i][j]=1, B[j]=2 -> every C[i]=32.
- A[i][j]=i-j, B[j]=-1 -> C[i]=120-16i, e.g. C[0]=120, C[15]=-120.
- A[i][j]=0x7FFFFFFF, B[j]=2 -> C[i]=0xFFFFFFE0 (wrapped).
- Reset asserted in CALC, then released and start pulsed -> done=0 immediately, WE=0; second run yields correct C and a single done.
